// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box op encoding plus the substitution scheduler's
// state encoding and per-requester byte counts.
package aes_pkg;

   localparam int              OP_W   = 2;
   localparam logic [OP_W-1:0] OP_FWD = 2'b01;
   localparam logic [OP_W-1:0] OP_INV = 2'b10;

   localparam int ST_BYTES = 16;
   localparam int KS_BYTES = 4;

   typedef logic [2:0] sched_state_t;

   localparam sched_state_t S_IDLE    = 3'd0;
   localparam sched_state_t S_ST_RUN  = 3'd1;
   localparam sched_state_t S_KS_RUN  = 3'd2;
   localparam sched_state_t S_ST_DONE = 3'd3;
   localparam sched_state_t S_KS_DONE = 3'd4;

endpackage

// File: rtl/aes_sbox_lut.sv
// Single-byte AES S-box, forward or inverse selected by op_i; purely combinational.
// Both directions share one GF(2^8) inverter, with the affine maps wrapped around it.
module aes_sbox_lut
   import aes_pkg::*;
(
   input  logic [OP_W-1:0] op_i,
   input  logic [7:0]      data_i,
   output logic [7:0]      data_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         r = gf_mul(gf_mul(r, r), a);
      end
      return gf_mul(r, r);
   endfunction

   function automatic logic [7:0] fwd_affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   logic       w_inv_sel;
   logic [7:0] w_gf_in;
   logic [7:0] w_gf_out;

   assign w_inv_sel = (op_i == OP_INV);
   assign w_gf_in   = w_inv_sel ? inv_affine(data_i) : data_i;
   assign w_gf_out  = gf_inv(w_gf_in);
   assign data_o    = w_inv_sel ? w_gf_out : fwd_affine(w_gf_out);

endmodule

// File: rtl/aes_sbox_sched.sv
// Shares one S-box between a 16-byte state pass (result at T+17) and a 4-byte key word (T+5);
// results hold valid until ready, and no new grant is issued until the FSM is back in IDLE.
module aes_sbox_sched
   import aes_pkg::*;
#(
   parameter int RrArb = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            st_req_i,
   input  logic [OP_W-1:0] st_op_i,
   input  logic [127:0]    st_data_i,
   output logic            st_gnt_o,
   output logic            st_valid_o,
   output logic [127:0]    st_data_o,
   input  logic            st_ready_i,
   input  logic            ks_req_i,
   input  logic [31:0]     ks_data_i,
   output logic            ks_gnt_o,
   output logic            ks_valid_o,
   output logic [31:0]     ks_data_o,
   input  logic            ks_ready_i,
   output logic            busy_o
);

   sched_state_t    r_state;
   logic [3:0]      r_cnt;
   logic            r_last_ks;
   logic [127:0]    r_st_in;
   logic [OP_W-1:0] r_st_op;
   logic [31:0]     r_ks_in;
   logic [127:0]    r_st_out;
   logic [31:0]     r_ks_out;

   logic            w_idle;
   logic            w_st_tie_win;
   logic            w_st_gnt;
   logic            w_ks_gnt;
   logic [7:0]      w_lut_in;
   logic [OP_W-1:0] w_lut_op;
   logic [7:0]      w_lut_out;

   // Fixed priority favours KS on a tie; round-robin favours whoever was not granted last
   assign w_idle       = (r_state == S_IDLE) && !rst_i;
   assign w_st_tie_win = (RrArb != 0) && r_last_ks;
   assign w_st_gnt     = w_idle && st_req_i && (!ks_req_i || w_st_tie_win);
   assign w_ks_gnt     = w_idle && ks_req_i && !w_st_gnt;

   assign w_lut_in = (r_state == S_ST_RUN) ? r_st_in[{r_cnt, 3'b000} +: 8]
                                           : r_ks_in[{r_cnt[1:0], 3'b000} +: 8];
   assign w_lut_op = (r_state == S_ST_RUN) ? r_st_op : OP_FWD;

   aes_sbox_lut u_lut (
      .op_i   (w_lut_op),
      .data_i (w_lut_in),
      .data_o (w_lut_out)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_last_ks <= 1'b1;
         r_st_in   <= '0;
         r_st_op   <= OP_FWD;
         r_ks_in   <= '0;
         r_st_out  <= '0;
         r_ks_out  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_st_gnt) begin
                  r_st_in   <= st_data_i;
                  r_st_op   <= st_op_i;
                  r_last_ks <= 1'b0;
                  r_state   <= S_ST_RUN;
               end else if (w_ks_gnt) begin
                  r_ks_in   <= ks_data_i;
                  r_last_ks <= 1'b1;
                  r_state   <= S_KS_RUN;
               end
            end
            S_ST_RUN: begin
               r_st_out[{r_cnt, 3'b000} +: 8] <= w_lut_out;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'(ST_BYTES - 1)) r_state <= S_ST_DONE;
            end
            S_KS_RUN: begin
               r_ks_out[{r_cnt[1:0], 3'b000} +: 8] <= w_lut_out;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'(KS_BYTES - 1)) r_state <= S_KS_DONE;
            end
            S_ST_DONE: begin
               if (st_ready_i) r_state <= S_IDLE;
            end
            S_KS_DONE: begin
               if (ks_ready_i) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign st_gnt_o   = w_st_gnt;
   assign ks_gnt_o   = w_ks_gnt;
   assign st_valid_o = (r_state == S_ST_DONE);
   assign ks_valid_o = (r_state == S_KS_DONE);
   assign st_data_o  = r_st_out;
   assign ks_data_o  = r_ks_out;
   assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Bench for aes_sbox_sched: transaction-level model checked every cycle, directed pins, random traffic.
// A second instance with fixed priority checks KS always wins a sustained tie.
module tb_aes_sbox_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         st_req, st_ready, ks_req, ks_ready;
   logic [1:0]   st_op;
   logic [127:0] st_data;
   logic [31:0]  ks_data;
   logic         st_gnt, st_valid, ks_gnt, ks_valid, busy;
   logic [127:0] st_dout;
   logic [31:0]  ks_dout;

   logic         fx_st_req, fx_ks_req;
   logic [127:0] fx_st_data;
   logic [31:0]  fx_ks_data;
   logic         fx_st_gnt, fx_st_valid, fx_ks_gnt, fx_ks_valid, fx_busy;
   logic [127:0] fx_st_dout;
   logic [31:0]  fx_ks_dout;

   aes_sbox_sched #(.RrArb(1)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .st_req_i(st_req), .st_op_i(st_op), .st_data_i(st_data), .st_gnt_o(st_gnt),
      .st_valid_o(st_valid), .st_data_o(st_dout), .st_ready_i(st_ready),
      .ks_req_i(ks_req), .ks_data_i(ks_data), .ks_gnt_o(ks_gnt),
      .ks_valid_o(ks_valid), .ks_data_o(ks_dout), .ks_ready_i(ks_ready),
      .busy_o(busy)
   );

   aes_sbox_sched #(.RrArb(0)) u_fx (
      .clk_i(clk), .rst_i(rst),
      .st_req_i(fx_st_req), .st_op_i(2'b01), .st_data_i(fx_st_data), .st_gnt_o(fx_st_gnt),
      .st_valid_o(fx_st_valid), .st_data_o(fx_st_dout), .st_ready_i(1'b1),
      .ks_req_i(fx_ks_req), .ks_data_i(fx_ks_data), .ks_gnt_o(fx_ks_gnt),
      .ks_valid_o(fx_ks_valid), .ks_data_o(fx_ks_dout), .ks_ready_i(1'b1),
      .busy_o(fx_busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic fail_to(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s bound expired t=%0t", name, $time);
   endtask

   // Polynomial product then reduction modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] poly_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic build_tables();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (poly_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         fwd_tab[x] = s;
         inv_tab[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] sub_state(input logic [127:0] d, input logic [1:0] op);
      logic [127:0] r;
      for (int k = 0; k < 16; k++)
         r[k*8 +: 8] = (op == 2'b10) ? inv_tab[d[k*8 +: 8]] : fwd_tab[d[k*8 +: 8]];
      return r;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] d);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[k*8 +: 8] = fwd_tab[d[k*8 +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] merge(input logic [127:0] prev, input logic [127:0] res, input int n);
      logic [127:0] r;
      r = prev;
      for (int k = 0; k < 16; k++) if (k < n) r[k*8 +: 8] = res[k*8 +: 8];
      return r;
   endfunction

   // Model: which requester owns the S-box, how many result bytes are visible, who won last
   int           m_phase;
   logic         m_last_ks;
   logic [127:0] m_st_prev, m_st_res;
   int           m_st_n;
   logic [31:0]  m_ks_prev, m_ks_res;
   int           m_ks_n;
   logic         e_idle, e_st_gnt, e_ks_gnt;
   logic [127:0] e_st_dat, e_ks_dat;

   task automatic model_reset();
      m_phase   = 0;
      m_last_ks = 1'b1;
      m_st_prev = '0; m_st_res = '0; m_st_n = 16;
      m_ks_prev = '0; m_ks_res = '0; m_ks_n = 4;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         e_idle   = (m_phase == 0) && !rst;
         e_st_gnt = e_idle && st_req && (!ks_req || m_last_ks);
         e_ks_gnt = e_idle && ks_req && !e_st_gnt;
         e_st_dat = merge(m_st_prev, m_st_res, m_st_n);
         e_ks_dat = merge({96'h0, m_ks_prev}, {96'h0, m_ks_res}, m_ks_n);
         check("st_gnt", st_gnt, e_st_gnt);
         check("ks_gnt", ks_gnt, e_ks_gnt);
         check("busy", busy, m_phase != 0);
         check("st_valid", st_valid, (m_phase == 1) && (m_st_n == 16));
         check("ks_valid", ks_valid, (m_phase == 2) && (m_ks_n == 4));
         check("st_data", st_dout, e_st_dat);
         check("ks_data", ks_dout, e_ks_dat);
         if (rst) begin
            model_reset();
         end else begin
            case (m_phase)
               0: begin
                  if (e_st_gnt) begin
                     m_st_prev = e_st_dat; m_st_res = sub_state(st_data, st_op);
                     m_st_n = 0; m_phase = 1; m_last_ks = 1'b0;
                  end else if (e_ks_gnt) begin
                     m_ks_prev = e_ks_dat[31:0]; m_ks_res = sub_word(ks_data);
                     m_ks_n = 0; m_phase = 2; m_last_ks = 1'b1;
                  end
               end
               1: if (m_st_n < 16) m_st_n++; else if (st_ready) m_phase = 0;
               default: if (m_ks_n < 4) m_ks_n++; else if (ks_ready) m_phase = 0;
            endcase
         end
      end
   end

   task automatic wait_gnt(input bit is_st, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if ((is_st ? st_gnt : ks_gnt) === 1'b1) ok = 1'b1;
         @(posedge clk); #1;
      end
      if (!ok) fail_to(is_st ? "st_gnt_wait" : "ks_gnt_wait");
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (busy === 1'b0) done = 1'b1;
         @(posedge clk); #1;
      end
      if (!done) fail_to("idle_wait");
   endtask

   task automatic run_st(input logic [127:0] d, input logic [1:0] op, input logic [127:0] exp,
                         input string nm, input int stall);
      bit ok, seen;
      int lat;
      st_req = 1'b1; st_data = d; st_op = op; st_ready = (stall == 0);
      wait_gnt(1'b1, ok);
      if (!ok) return;
      st_req = 1'b0; st_data = {$urandom, $urandom, $urandom, $urandom}; st_op = 2'($urandom_range(0, 3));
      lat = 1; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (st_valid === 1'b1) begin seen = 1'b1; break; end
         @(posedge clk); #1;
         lat++;
      end
      if (!seen) begin fail_to({nm, "_valid_wait"}); @(posedge clk); #1; return; end
      check({nm, "_lat"}, lat, 17);
      check({nm, "_dat"}, st_dout, exp);
      for (int s = 0; s < stall; s++) begin
         check({nm, "_hold_valid"}, st_valid, 1'b1);
         check({nm, "_hold_busy"}, busy, 1'b1);
         check({nm, "_hold_nognt"}, st_gnt | ks_gnt, 1'b0);
         check({nm, "_hold_dat"}, st_dout, exp);
         @(posedge clk); #1;
         if (s == stall - 1) st_ready = 1'b1;
         @(negedge clk);
      end
      check({nm, "_hs_nognt"}, st_gnt | ks_gnt, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check({nm, "_valid_drop"}, st_valid, 1'b0);
      check({nm, "_dat_kept"}, st_dout, exp);
      @(posedge clk); #1;
   endtask

   task automatic run_ks(input logic [31:0] d, input logic [31:0] exp, input string nm);
      bit ok, seen;
      int lat;
      ks_req = 1'b1; ks_data = d; ks_ready = 1'b1;
      wait_gnt(1'b0, ok);
      if (!ok) return;
      ks_req = 1'b0; ks_data = $urandom;
      lat = 1; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ks_valid === 1'b1) begin seen = 1'b1; break; end
         @(posedge clk); #1;
         lat++;
      end
      if (!seen) begin fail_to({nm, "_valid_wait"}); @(posedge clk); #1; return; end
      check({nm, "_lat"}, lat, 5);
      check({nm, "_dat"}, ks_dout, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      bit ok;
      int prev_w, cur_w, n_g, fx_st_cnt, fx_ks_cnt;
      build_tables();
      model_reset();
      rst = 1'b1;
      st_req = 1'b0; st_op = 2'b01; st_data = '0; st_ready = 1'b1;
      ks_req = 1'b0; ks_data = '0; ks_ready = 1'b1;
      fx_st_req = 1'b0; fx_ks_req = 1'b0; fx_st_data = '0; fx_ks_data = 32'h01020304;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_st_valid", st_valid, 1'b0);
      check("rst_st_dat", st_dout, 128'h0);
      check("rst_ks_dat", ks_dout, 32'h0);
      @(posedge clk); #1;

      run_st({16{8'h00}}, 2'b01, {16{8'h63}}, "st_fwd_zero", 0);
      run_st({16{8'h63}}, 2'b10, {16{8'h00}}, "st_inv_63", 0);
      run_st({16{8'h53}}, 2'b11, {16{8'hED}}, "st_op11_53", 0);
      run_ks(32'h01020304, 32'h7C777BF2, "ks_word");

      // ST wins the tie (KS went last), then waits 10 cycles for ready while KS keeps asking
      ks_req = 1'b1; ks_data = 32'h01020304;
      run_st({16{8'h00}}, 2'b01, {16{8'h63}}, "st_stall", 10);
      ks_req = 1'b0;
      wait_idle();

      st_req = 1'b1; st_data = {$urandom, $urandom, $urandom, $urandom}; st_op = 2'b01; st_ready = 1'b1;
      wait_gnt(1'b1, ok);
      st_req = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 1'b0);
      check("midrst_st_dat", st_dout, 128'h0);
      check("midrst_ks_dat", ks_dout, 32'h0);
      for (int i = 0; i < 20; i++) begin
         check("midrst_no_valid", st_valid, 1'b0);
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      run_st({4{32'h04030201}}, 2'b01, {4{32'hF27B777C}}, "st_after_rst", 0);

      st_req = 1'b1; ks_req = 1'b1; st_ready = 1'b1; ks_ready = 1'b1;
      st_data = {$urandom, $urandom, $urandom, $urandom}; ks_data = $urandom; st_op = 2'b10;
      prev_w = 0; n_g = 0;
      for (int i = 0; i < 200 && n_g < 6; i++) begin
         @(negedge clk);
         if (st_gnt === 1'b1 || ks_gnt === 1'b1) begin
            cur_w = (st_gnt === 1'b1) ? 1 : 2;
            if (n_g > 0) check("rr_alternate", cur_w, (prev_w == 1) ? 2 : 1);
            prev_w = cur_w;
            n_g++;
         end
         @(posedge clk); #1;
      end
      if (n_g < 6) fail_to("rr_grants");
      st_req = 1'b0; ks_req = 1'b0;
      wait_idle();

      fx_st_req = 1'b1; fx_ks_req = 1'b1;
      fx_st_cnt = 0; fx_ks_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (fx_st_gnt === 1'b1) fx_st_cnt++;
         if (fx_ks_gnt === 1'b1) fx_ks_cnt++;
         @(posedge clk); #1;
      end
      fx_st_req = 1'b0; fx_ks_req = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("fx_st_grants", fx_st_cnt, 0);
      check("fx_ks_grants", fx_ks_cnt, 14);
      check("fx_ks_dat", fx_ks_dout, 32'h7C777BF2);
      check("fx_st_dat", fx_st_dout, 128'h0);
      @(posedge clk); #1;

      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 249) == 0);
         st_req   = 1'($urandom_range(0, 1));
         ks_req   = 1'($urandom_range(0, 1));
         st_op    = 2'($urandom_range(0, 3));
         st_data  = {$urandom, $urandom, $urandom, $urandom};
         ks_data  = $urandom;
         st_ready = ($urandom_range(0, 3) != 0);
         ks_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      rst = 1'b0; st_req = 1'b0; ks_req = 1'b0; st_ready = 1'b1; ks_ready = 1'b1;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_sbox_sched.md
AES_SBOX_SCHED -- requirements
Module: aes_sbox_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter RrArb, default 1: 1 = round-robin arbitration, 0 = fixed priority with key-schedule first.

Ports:
REQ-002 The block SHALL have `clk_i` (input, 1): the only clock; one clock, all logic on its rising edge.
REQ-003 The block SHALL have `rst_i` (input, 1): reset, synchronous and active-high.
REQ-004 The block SHALL have `st_req_i` (input, 1): state requester wants a 16-byte SubBytes pass.
REQ-005 The block SHALL have `st_op_i` (input, 2): 2'b01 selects forward S-box, 2'b10 inverse, any other value forward.
REQ-006 The block SHALL have `st_data_i` (input, 128): state; byte k is bits [8k+7:8k].
REQ-007 The block SHALL have `st_gnt_o` (output, 1): state request accepted this cycle.
REQ-008 The block SHALL have `st_valid_o`, `st_data_o` (output, 1 / 128) and `st_ready_i` (input, 1): state result handshake.
REQ-009 The block SHALL have `ks_req_i` (input, 1) and `ks_data_i` (input, 32): key-schedule word substitution request; always uses the forward S-box.
REQ-010 The block SHALL have `ks_gnt_o` (output, 1): key-schedule request accepted this cycle.
REQ-011 The block SHALL have `ks_valid_o`, `ks_data_o` (output, 1 / 32) and `ks_ready_i` (input, 1): key-schedule result handshake.
REQ-012 The block SHALL have `busy_o` (output, 1): high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL time-share exactly one S-box LUT instance between both requesters, one byte per cycle.
REQ-014 The FSM SHALL have exactly these states: IDLE, ST_RUN, KS_RUN, ST_DONE, KS_DONE.
REQ-015 In IDLE, `*_gnt_o` SHALL be driven combinationally: only one requester → grant it; both requesting → grant the one not granted last (RrArb=1) or KS (RrArb=0).
REQ-016 On a grant cycle T, the block SHALL capture the data (and `st_op_i`), clear the byte counter to 0 and enter the matching RUN state at T+1.
REQ-017 In RUN, byte[cnt] SHALL be substituted and written into the output register at the same byte index each cycle, then cnt increments.
REQ-018 ST_RUN SHALL last 16 cycles (cnt 0..15) and KS_RUN 4 cycles (cnt 0..3); on the last byte the FSM moves to DONE.
REQ-019 Latency: `st_valid_o` SHALL rise at T+17 and `ks_valid_o` at T+5.
REQ-020 In DONE, `*_valid_o` SHALL stay high and `*_data_o` stable until a cycle where `*_ready_i` is high, then the FSM returns to IDLE; `valid_o` is low at the next cycle.
REQ-021 No grant SHALL be issued in RUN, DONE, or on the handshake cycle; a new grant is possible no earlier than the cycle after the FSM re-enters IDLE.
REQ-022 Inputs SHALL be ignored outside grant cycles; `req_i` deasserting mid-operation SHALL have no effect.
REQ-023 `*_data_o` SHALL hold the last completed result after `valid_o` drops, and SHALL be overwritten byte-by-byte during the next RUN of that requester only.
REQ-024 The last-granted flag SHALL update only on grant cycles.

Reset
REQ-025 On `rst_i` high at a clock edge, the block SHALL force: state = IDLE, cnt = 0, all valid/gnt = 0, `busy_o` = 0, `st_data_o` = 0, `ks_data_o` = 0, and last-granted = KS (so ST wins the first tie).
REQ-026 A reset mid-RUN or mid-DONE SHALL discard the operation with no valid pulse.
REQ-027 Grants SHALL be suppressed while `rst_i` is high.

Structure
REQ-028 The op encoding and op width constant SHALL be taken from the shared `aes_pkg`.
REQ-029 The FSM state typedef and the byte counts (16, 4) SHALL be added to `aes_pkg`.
REQ-030 The block SHALL contain a single sub-module: the existing `aes_sbox_lut`, with `op_i` muxed between the captured `st_op_i` and forward.
REQ-031 Implementation size: the target is 120-400 RTL lines.

Verification
REQ-032 ST all-zero, op 2'b01 → `st_data_o` = all bytes 8'h63, valid at T+17.
REQ-033 ST all bytes 8'h63, op 2'b10 → all zero; op 2'b11 with 8'h53 bytes → all 8'hED (forward).
REQ-034 KS 32'h01020304 → `ks_data_o` = 32'h7C777BF2, valid at T+5.
REQ-035 Both requests held continuously, RrArb=1 → grants alternate ST, KS, ST…; with RrArb=0 → KS always wins.
REQ-036 Hold `st_ready_i` low 10 cycles after valid → data stable, `busy_o` = 1, no grants until the handshake.
REQ-037 Assert `rst_i` at cnt = 7 of ST_RUN → next cycle IDLE, outputs zero, no valid; a fresh request then completes correctly.
